// File: rtl/hilo_muldiv_seq_if.sv
// Pipeline and divider signals of the HI/LO multiply/divide sequencer.
// The slave modport is the sequencer; the master modport drives ops and plays the divider.
interface hilo_muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             timeout;
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport master (
    output op_valid, op, op_a, op_b, flush, div_done, div_quot, div_rem,
    input  busy, hi, lo, timeout, div_start, div_signed, div_a, div_b
  );

  modport slave (
    input  op_valid, op, op_a, op_b, flush, div_done, div_quot, div_rem,
    output busy, hi, lo, timeout, div_start, div_signed, div_a, div_b
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// MIPS HI/LO register file with single-cycle multiply and a sequencer that drives an external
// multi-cycle divider, holding busy until the quotient/remainder are committed.
module hilo_muldiv_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  hilo_muldiv_seq_if.slave bus
);

  localparam int unsigned     CntW   = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_TIMEOUT - 1);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             div_signed_q, div_signed_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               accept;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  always_comb begin
    prod_u = {{WIDTH{1'b0}}, bus.op_a} * {{WIDTH{1'b0}}, bus.op_b};
    prod_s = {{WIDTH{bus.op_a[WIDTH-1]}}, bus.op_a} * {{WIDTH{bus.op_b[WIDTH-1]}}, bus.op_b};
  end

  assign accept = bus.op_valid && !bus.flush;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    div_signed_d = div_signed_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.op)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpDiv, OpDivu: begin
              if (bus.op_b == '0) begin
                // Divide by zero never reaches the divider.
                lo_d = '1;
                hi_d = bus.op_a;
              end else begin
                div_a_d      = bus.op_a;
                div_b_d      = bus.op_b;
                div_signed_d = (bus.op == OpDiv);
                state_d      = StIssue;
              end
            end
            OpMthi:  hi_d = bus.op_a;
            OpMtlo:  lo_d = bus.op_a;
            default: ;
          endcase
        end
      end
      StIssue: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.div_done) begin
          lo_d    = bus.div_quot;
          hi_d    = bus.div_rem;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      div_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      div_signed_q <= div_signed_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.timeout    = timeout_q;
  // A flush during ISSUE cancels the start so the divider never sees the aborted op.
  assign bus.div_start  = (state_q == StIssue) && !bus.flush;
  assign bus.div_signed = div_signed_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq: the driver queues expected HI/LO results, a monitor
// checks them once busy is low, and a behavioural divider answers div_start.
module tb_hilo_muldiv_seq;

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          starts;
    int          busy_cyc;
    int          tos;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   div_lat = 34;
  exp_t sb_q[$];

  int          n_start = 0;
  int          n_busy  = 0;
  int          n_to    = 0;
  int          waited  = 0;
  logic [31:0] cap_a   = '0;
  logic [31:0] cap_b   = '0;
  logic        cap_sgn = 1'b0;

  hilo_muldiv_seq_if #(.WIDTH(32)) bus ();

  hilo_muldiv_seq #(
    .WIDTH       (32),
    .DIV_TIMEOUT (64)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.flush    = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input int starts, input int busy_cyc, input int tos,
                            input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.starts = starts; e.busy_cyc = busy_cyc;
    e.tos = tos; e.a = a; e.b = b; e.sgn = sgn;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue_left=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  // Monitor: results are committed once busy is low after an accepted op.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.div_start) begin
        n_start++;
        cap_a   = bus.div_a;
        cap_b   = bus.div_b;
        cap_sgn = bus.div_signed;
      end
      if (bus.busy) n_busy++;
      if (bus.timeout) n_to++;
      if (sb_q.size() != 0) begin
        waited++;
        if (!bus.busy || waited > 300) begin
          e = sb_q.pop_front();
          if (waited > 300) begin
            checks++;
            errors++;
            $display("FAIL %s_wait busy still high after %0d cycles", e.name, waited);
          end
          chk({e.name, "_hi"}, bus.hi, e.hi);
          chk({e.name, "_lo"}, bus.lo, e.lo);
          chk({e.name, "_starts"}, n_start, e.starts);
          chk({e.name, "_busy_cycles"}, n_busy, e.busy_cyc);
          chk({e.name, "_timeouts"}, n_to, e.tos);
          if (e.starts > 0) begin
            chk({e.name, "_div_a"}, cap_a, e.a);
            chk({e.name, "_div_b"}, cap_b, e.b);
            chk({e.name, "_div_signed"}, 32'(cap_sgn), 32'(e.sgn));
          end
          n_start = 0;
          n_busy  = 0;
          n_to    = 0;
          waited  = 0;
        end
      end
    end
  end

  // Behavioural divider: done arrives div_lat cycles after the start cycle; 0 = never.
  initial begin : divider_model
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    int lat;
    bus.div_done = 1'b0;
    bus.div_quot = '0;
    bus.div_rem  = '0;
    forever begin
      @(negedge clk);
      lat = div_lat;
      if (bus.div_start && lat > 0) begin
        repeat (lat) @(posedge clk);
        #1;
        sa = bus.div_a;
        sd = bus.div_b;
        if (bus.div_b == '0) begin
          bus.div_quot = '1;
          bus.div_rem  = bus.div_a;
        end else if (bus.div_signed) begin
          bus.div_quot = sa / sd;
          bus.div_rem  = sa % sd;
        end else begin
          bus.div_quot = bus.div_a / bus.div_b;
          bus.div_rem  = bus.div_a % bus.div_b;
        end
        bus.div_done = 1'b1;
        @(posedge clk);
        #1 bus.div_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    chk("rst_div_start", 32'(bus.div_start), 32'h0);
    chk("rst_div_ab", {bus.div_a[15:0], bus.div_b[15:0]}, 32'h0);
    chk("rst_div_signed", 32'(bus.div_signed), 32'h0);
    @(posedge clk);
    #1;

    issue(OpMult, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    expect_res("mult_neg1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMultu, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    expect_res("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMult, 32'h8000_0000, 32'h0000_0001, 1'b0);
    expect_res("mult_min_x1", 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMultu, 32'h8000_0000, 32'h8000_0000, 1'b0);
    expect_res("multu_2p31_sq", 32'h4000_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMthi, 32'h1111_2222, 32'h0, 1'b0);
    expect_res("mthi", 32'h1111_2222, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMtlo, 32'h3333_4444, 32'h0, 1'b0);
    expect_res("mtlo", 32'h1111_2222, 32'h3333_4444, 0, 0, 0, 0, 0, 0);
    wait_drain();

    div_lat = 34;
    issue(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    expect_res("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 35, 0, 32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_drain();

    // MTHI presented while busy must be dropped.
    issue(OpDivu, 32'h0000_0005, 32'h0000_0002, 1'b0);
    expect_res("divu_5_2", 32'h0000_0001, 32'h0000_0002, 1, 35, 0, 32'h5, 32'h2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    issue(OpMthi, 32'h0000_ABCD, 32'h0, 1'b0);
    wait_drain();
    issue(OpMthi, 32'h0000_ABCD, 32'h0, 1'b0);
    expect_res("mthi_after_busy", 32'h0000_ABCD, 32'h0000_0002, 0, 0, 0, 0, 0, 0);
    wait_drain();

    issue(OpDivu, 32'h1234_5678, 32'h0, 1'b0);
    expect_res("divu_by_zero", 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpDiv, 32'h8000_0000, 32'h0, 1'b0);
    expect_res("div_by_zero", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    wait_drain();
    issue(OpMtlo, 32'h0000_DEAD, 32'h0, 1'b1);
    expect_res("flush_idle_mtlo", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    wait_drain();

    // Flush on the 11th WAIT cycle; the divider still answers later and must be ignored.
    div_lat = 34;
    issue(OpDivu, 32'd100, 32'd7, 1'b0);
    expect_res("flush_wait", 32'h8000_0000, 32'hFFFF_FFFF, 1, 12, 0, 32'd100, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    issue(OpMtlo, 32'h0000_0F0F, 32'h0, 1'b0);
    expect_res("late_done_ignored", 32'h8000_0000, 32'h0000_0F0F, 0, 0, 0, 0, 0, 0);
    wait_drain();

    // Done on the last WAIT cycle beats the timeout.
    div_lat = 64;
    issue(OpDivu, 32'd100, 32'd7, 1'b0);
    expect_res("done_at_limit", 32'h0000_0002, 32'h0000_000E, 1, 65, 0, 32'd100, 32'd7, 1'b0);
    wait_drain();

    div_lat = 0;
    issue(OpDiv, 32'hFFFF_FF9C, 32'd7, 1'b0);
    expect_res("timeout", 32'h0000_0002, 32'h0000_000E, 1, 65, 1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_drain();

    // Async reset during WAIT.
    div_lat = 34;
    issue(OpDivu, 32'h0000_0005, 32'h0000_0002, 1'b0);
    expect_res("rst_mid_wait", 32'h0, 32'h0, 1, 12, 0, 32'h5, 32'h2, 1'b0);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(bus.busy), 32'h0);
    chk("rst_async_hi", bus.hi, 32'h0);
    chk("rst_async_lo", bus.lo, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    issue(OpMtlo, 32'h0000_0055, 32'h0, 1'b0);
    expect_res("post_rst_no_start", 32'h0, 32'h0000_0055, 0, 0, 0, 0, 0, 0);
    wait_drain();

    // Flush during ISSUE suppresses the start pulse.
    div_lat = 34;
    issue(OpDivu, 32'd9, 32'd4, 1'b0);
    expect_res("flush_issue", 32'h0, 32'h0000_0055, 0, 1, 0, 0, 0, 0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
